// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cu_pkg
// Description : Shared control-unit constants, state type and decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cu_pkg;

    localparam logic [7:0] R8_B = 8'h01;
    localparam logic [7:0] R8_C = 8'h02;
    localparam logic [7:0] R8_D = 8'h04;
    localparam logic [7:0] R8_E = 8'h08;
    localparam logic [7:0] R8_H = 8'h10;
    localparam logic [7:0] R8_L = 8'h20;
    localparam logic [7:0] R8_Z = 8'h40;
    localparam logic [7:0] R8_W = 8'h80;

    localparam logic [5:0] R16_BC = 6'h01;
    localparam logic [5:0] R16_DE = 6'h02;
    localparam logic [5:0] R16_HL = 6'h04;
    localparam logic [5:0] R16_SP = 6'h08;
    localparam logic [5:0] R16_PC = 6'h10;
    localparam logic [5:0] R16_WZ = 6'h20;

    localparam logic [1:0] INC_NONE  = 2'b00;
    localparam logic [1:0] INC_UP    = 2'b01;
    localparam logic [1:0] INC_DOWN  = 2'b10;
    localparam logic [1:0] BYTE_NONE = 2'b00;
    localparam logic [1:0] BYTE_LO   = 2'b01;
    localparam logic [1:0] BYTE_HI   = 2'b10;

    localparam logic [1:0] CC_NZ = 2'd0;
    localparam logic [1:0] CC_Z  = 2'd1;
    localparam logic [1:0] CC_NC = 2'd2;
    localparam logic [1:0] CC_C  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FETCH = 2'd2
    } seq_state_t;

    // Instruction length in M-cycles, trailing fetch included.
    function automatic logic [2:0] instr_len(input logic [5:0] yz, input logic taken);
        logic [2:0] y;
        logic [2:0] z;
        y = yz[5:3];
        z = yz[2:0];
        instr_len = 3'd1;
        if (z == 3'd0) begin
            if (y == 3'd1)
                instr_len = 3'd5;
            else if (y == 3'd3)
                instr_len = 3'd3;
            else if (y[2])
                instr_len = taken ? 3'd3 : 3'd2;
        end else if (z == 3'd1 && !y[0]) begin
            instr_len = 3'd3;
        end
    endfunction

    function automatic logic cond_true(input logic [1:0] cc, input logic flag_z, input logic flag_c);
        case (cc)
            CC_NZ:   cond_true = !flag_z;
            CC_Z:    cond_true = flag_z;
            CC_NC:   cond_true = !flag_c;
            default: cond_true = flag_c;
        endcase
    endfunction

    // Byte target of a register pair; SP is staged through W:Z.
    function automatic logic [7:0] rp_byte(input logic [1:0] p, input logic hi);
        case (p)
            2'd0:    rp_byte = hi ? R8_B : R8_C;
            2'd1:    rp_byte = hi ? R8_D : R8_E;
            2'd2:    rp_byte = hi ? R8_H : R8_L;
            default: rp_byte = hi ? R8_W : R8_Z;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/x0_step_counter.sv
`default_nettype none
// ============================================================================
// Module      : x0_step_counter
// Description : T-step / M-cycle counter with wait freeze and restart.
// Revision    : 1.0 - initial release
// ============================================================================
module x0_step_counter #(
    parameter int STEPS_PER_M = 4,
    parameter int CNT_W       = 3,
    localparam int T_W        = $clog2(STEPS_PER_M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_wait,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_m_cycle,
    output logic [T_W-1:0]   o_t_step,
    output logic             o_last_step
);

    assign o_last_step = (o_t_step == T_W'(STEPS_PER_M - 1));

    // Restart outranks the wait freeze so an accepted opcode always begins at m0/t0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_m_cycle <= '0;
            o_t_step  <= '0;
        end else if (i_clear) begin
            o_m_cycle <= '0;
            o_t_step  <= '0;
        end else if (i_enable && !i_wait) begin
            if (o_last_step) begin
                o_t_step  <= '0;
                o_m_cycle <= o_m_cycle + 1'b1;
            end else begin
                o_t_step  <= o_t_step + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/x0_microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : x0_microcode_sequencer
// Description : Sequential X=0 opcode-group microcode sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module x0_microcode_sequencer
    import cu_pkg::*;
#(
    parameter int STEPS_PER_M = 4,
    parameter int ISSUE_STEP  = 1,
    parameter int CNT_W       = 3,
    localparam int T_W        = $clog2(STEPS_PER_M)
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Start,
    input  logic [7:0]       i_Opcode,
    input  logic [3:0]       i_Conditions,
    input  logic             i_Wait,
    output logic             o_Busy,
    output logic [CNT_W-1:0] o_M_Cycle,
    output logic [T_W-1:0]   o_T_Step,
    output logic             o_Fetch,
    output logic [7:0]       o_Write8,
    output logic [5:0]       o_Read16,
    output logic [5:0]       o_Write16,
    output logic             o_Bus_In,
    output logic             o_Bus_Out,
    output logic             o_Address_Out,
    output logic [1:0]       o_Increment16,
    output logic [1:0]       o_Bus16_Byte_To_Bus,
    output logic             o_Pc_Add_Z
);

    // Two-strobe store steps; pulled back one step when ISSUE_STEP is the last step.
    localparam int c_S1 = (ISSUE_STEP == STEPS_PER_M - 1) ? STEPS_PER_M - 2 : ISSUE_STEP;
    localparam int c_S2 = c_S1 + 1;

    seq_state_t       r_state;
    logic [5:0]       r_op;
    logic             r_taken;
    logic [CNT_W-1:0] w_m;
    logic [T_W-1:0]   w_t;
    logic             w_last, w_issue, w_accept, w_fetch_done, w_clear;
    logic             w_cc_true, w_taken_now, w_m0;
    logic [2:0]       w_len, w_new_len, w_y, w_z;
    logic             w_imm;
    logic [7:0]       w_dst;
    logic             w_unused_nh;

    // N and H have no consumer in this opcode group.
    assign w_unused_nh = ^i_Conditions[2:1];

    x0_step_counter #(
        .STEPS_PER_M (STEPS_PER_M),
        .CNT_W       (CNT_W)
    ) u_step_counter (
        .clk         (i_Clk),
        .rst         (i_Reset),
        .i_clear     (w_clear),
        .i_wait      (i_Wait),
        .i_enable    (r_state != ST_IDLE),
        .o_m_cycle   (w_m),
        .o_t_step    (w_t),
        .o_last_step (w_last)
    );

    assign w_y          = r_op[5:3];
    assign w_z          = r_op[2:0];
    assign w_m0         = (w_m == '0);
    assign w_issue      = (w_t == T_W'(ISSUE_STEP));
    assign w_fetch_done = (r_state == ST_FETCH) && w_last && !i_Wait;
    assign w_accept     = i_Start && (i_Opcode[7:6] == 2'b00) &&
                          ((r_state == ST_IDLE) || w_fetch_done);
    assign w_clear      = w_accept || w_fetch_done;
    assign w_cc_true    = cond_true(w_y[1:0], i_Conditions[3], i_Conditions[0]);
    assign w_taken_now  = (w_m0 && w_issue) ? w_cc_true : r_taken;
    assign w_len        = instr_len(r_op, w_taken_now);
    assign w_new_len    = instr_len(i_Opcode[5:0], 1'b1);

    assign o_Busy    = (r_state != ST_IDLE);
    assign o_M_Cycle = w_m;
    assign o_T_Step  = w_t;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_taken <= 1'b0;
        end else begin
            if (r_state == ST_EXEC && w_m0 && w_issue)
                r_taken <= w_cc_true;
            if (w_accept) begin
                r_op    <= i_Opcode[5:0];
                r_state <= (w_new_len == 3'd1) ? ST_FETCH : ST_EXEC;
            end else begin
                unique case (r_state)
                    ST_EXEC: begin
                        if (w_last && !i_Wait && (w_m == CNT_W'(w_len) - CNT_W'(2)))
                            r_state <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        if (w_fetch_done)
                            r_state <= ST_IDLE;
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    // Microprogram ROM, decoded from the latched opcode and current step.
    always_comb begin
        o_Fetch             = 1'b0;
        o_Write8            = '0;
        o_Read16            = '0;
        o_Write16           = '0;
        o_Bus_In            = 1'b0;
        o_Bus_Out           = 1'b0;
        o_Address_Out       = 1'b0;
        o_Increment16       = INC_NONE;
        o_Bus16_Byte_To_Bus = BYTE_NONE;
        o_Pc_Add_Z          = 1'b0;
        w_imm               = 1'b0;
        w_dst               = '0;
        if (r_state == ST_FETCH) begin
            o_Fetch = w_issue;
        end else if (r_state == ST_EXEC) begin
            if (w_z == 3'd0 && w_y == 3'd1) begin
                if (w_m < CNT_W'(2)) begin
                    w_imm = w_issue;
                    w_dst = w_m0 ? R8_Z : R8_W;
                end else if (w_t == T_W'(c_S1)) begin
                    o_Read16      = R16_WZ;
                    o_Address_Out = 1'b1;
                    o_Increment16 = INC_UP;
                end else if (w_t == T_W'(c_S2)) begin
                    o_Read16            = R16_SP;
                    o_Bus_Out           = 1'b1;
                    o_Bus16_Byte_To_Bus = (w_m == CNT_W'(2)) ? BYTE_LO : BYTE_HI;
                end
            end else if (w_z == 3'd0 && w_y >= 3'd3) begin
                if (w_m0) begin
                    w_imm = w_issue;
                    w_dst = R8_Z;
                end else begin
                    o_Pc_Add_Z = w_issue;
                end
            end else if (w_z == 3'd1 && !w_y[0]) begin
                w_imm = w_issue;
                w_dst = rp_byte(w_y[2:1], !w_m0);
                if (!w_m0 && w_y[2:1] == 2'd3 && w_issue) begin
                    o_Write16 = R16_SP;
                    o_Read16  = R16_WZ;
                end
            end
            if (w_imm) begin
                o_Read16      = o_Read16 | R16_PC;
                o_Address_Out = 1'b1;
                o_Bus_In      = 1'b1;
                o_Write8      = w_dst;
                o_Increment16 = INC_UP;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_x0_microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_x0_microcode_sequencer
// Description : Directed self-checking bench for x0_microcode_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_x0_microcode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_Start;
    logic [7:0] i_Opcode;
    logic [3:0] i_Conditions;
    logic       i_Wait;
    logic       o_Busy;
    logic [2:0] o_M_Cycle;
    logic [1:0] o_T_Step;
    logic       o_Fetch;
    logic [7:0] o_Write8;
    logic [5:0] o_Read16;
    logic [5:0] o_Write16;
    logic       o_Bus_In, o_Bus_Out, o_Address_Out, o_Pc_Add_Z;
    logic [1:0] o_Increment16, o_Bus16_Byte_To_Bus;

    int n_vec     = 0;
    int n_miscmp  = 0;
    logic [28:0] exp_a [6];
    logic [28:0] exp_b [6];
    logic [28:0] w_obs;

    always #5 clk = ~clk;

    x0_microcode_sequencer #(.STEPS_PER_M(4), .ISSUE_STEP(1), .CNT_W(3)) dut (
        .i_Clk               (clk),
        .i_Reset             (rst),
        .i_Start             (i_Start),
        .i_Opcode            (i_Opcode),
        .i_Conditions        (i_Conditions),
        .i_Wait              (i_Wait),
        .o_Busy              (o_Busy),
        .o_M_Cycle           (o_M_Cycle),
        .o_T_Step            (o_T_Step),
        .o_Fetch             (o_Fetch),
        .o_Write8            (o_Write8),
        .o_Read16            (o_Read16),
        .o_Write16           (o_Write16),
        .o_Bus_In            (o_Bus_In),
        .o_Bus_Out           (o_Bus_Out),
        .o_Address_Out       (o_Address_Out),
        .o_Increment16       (o_Increment16),
        .o_Bus16_Byte_To_Bus (o_Bus16_Byte_To_Bus),
        .o_Pc_Add_Z          (o_Pc_Add_Z)
    );

    assign w_obs = {o_Fetch, o_Write8, o_Read16, o_Write16, o_Bus_In, o_Bus_Out,
                    o_Address_Out, o_Increment16, o_Bus16_Byte_To_Bus, o_Pc_Add_Z};

    function automatic logic [28:0] cw(input logic f, input logic [7:0] w8,
                                       input logic [5:0] r16, w16,
                                       input logic bi, bo, ao,
                                       input logic [1:0] inc, byt, input logic pz);
        cw = {f, w8, r16, w16, bi, bo, ao, inc, byt, pz};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 6; i++) begin
            exp_a[i] = '0;
            exp_b[i] = '0;
        end
    endtask

    // Issue op from idle and walk it step by step; optional stall and stray start.
    task automatic run_instr(input string tag, input logic [7:0] op, input int len,
                             input int wpos, input int wn, input int poke);
        int pos, w, cyc, m, t;
        logic stall;
        logic [28:0] exp;
        i_Opcode = op;
        i_Start  = 1'b1;
        tick();
        i_Start = 1'b0;
        pos = 0; w = 0; cyc = 0;
        while (pos < len * 4 && cyc < 200) begin
            m = pos / 4;
            t = pos % 4;
            exp = (t == 1) ? exp_a[m] : (t == 2) ? exp_b[m] : '0;
            check($sformatf("%s m%0d t%0d ctl", tag, m, t), w_obs, exp);
            check($sformatf("%s m%0d t%0d pos", tag, m, t),
                  {o_Busy, o_M_Cycle, o_T_Step}, {1'b1, 3'(m), 2'(t)});
            if (pos == poke) begin
                i_Start  = 1'b1;
                i_Opcode = 8'h00;
            end else begin
                i_Start = 1'b0;
            end
            stall  = (pos == wpos) && (w < wn);
            i_Wait = stall;
            if (stall) w++;
            tick();
            cyc++;
            if (!stall) pos++;
        end
        i_Wait  = 1'b0;
        i_Start = 1'b0;
        check({tag, " idle"}, {o_Busy, o_M_Cycle, o_T_Step, w_obs}, '0);
    endtask

    logic [28:0] c_rd_z, c_rd_w, c_fetch;

    initial begin
        rst = 1'b1; i_Start = 1'b0; i_Opcode = 8'h00; i_Conditions = 4'h0; i_Wait = 1'b0;
        c_rd_z  = cw(0, 8'h40, 6'h10, 6'h00, 1, 0, 1, 2'b01, 2'b00, 0);
        c_rd_w  = cw(0, 8'h80, 6'h10, 6'h00, 1, 0, 1, 2'b01, 2'b00, 0);
        c_fetch = cw(1, 8'h00, 6'h00, 6'h00, 0, 0, 0, 2'b00, 2'b00, 0);
        tick();
        check("reset state", {o_Busy, o_M_Cycle, o_T_Step, w_obs}, '0);
        rst = 1'b0;

        // x=01 opcode is not part of this group
        i_Opcode = 8'h40; i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        check("x01 ignored", {o_Busy, o_M_Cycle, o_T_Step}, '0);
        tick();
        check("x01 still idle", o_Busy, 1'b0);

        // NOP then NOP with zero bubble
        i_Opcode = 8'h00; i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("b2b c%0d fetch", c), o_Fetch, (c == 2 || c == 6));
            check($sformatf("b2b c%0d busy", c), o_Busy, 1'b1);
            i_Start = (c == 4);
            tick();
        end
        i_Start = 1'b0;
        check("b2b end busy", o_Busy, 1'b0);

        clear_exp();
        exp_a[0] = cw(0, 8'h02, 6'h10, 6'h00, 1, 0, 1, 2'b01, 2'b00, 0);
        exp_a[1] = cw(0, 8'h01, 6'h10, 6'h00, 1, 0, 1, 2'b01, 2'b00, 0);
        exp_a[2] = c_fetch;
        run_instr("ld_bc", 8'h01, 3, -1, 0, -1);

        clear_exp();
        i_Conditions = 4'b1000;
        exp_a[0] = c_rd_z;
        exp_a[1] = c_fetch;
        run_instr("jrnz_nt", 8'h20, 2, -1, 0, -1);

        clear_exp();
        i_Conditions = 4'b0000;
        exp_a[0] = c_rd_z;
        exp_a[1] = cw(0, 8'h00, 6'h00, 6'h00, 0, 0, 0, 2'b00, 2'b00, 1);
        exp_a[2] = c_fetch;
        run_instr("jrnz_t", 8'h20, 3, -1, 0, -1);
        run_instr("jr_poke", 8'h18, 3, -1, 0, 3);

        clear_exp();
        exp_a[0] = c_rd_z;
        exp_a[1] = c_rd_w;
        exp_a[2] = cw(0, 8'h00, 6'h20, 6'h00, 0, 0, 1, 2'b01, 2'b00, 0);
        exp_b[2] = cw(0, 8'h00, 6'h08, 6'h00, 0, 1, 0, 2'b00, 2'b01, 0);
        exp_a[3] = exp_a[2];
        exp_b[3] = cw(0, 8'h00, 6'h08, 6'h00, 0, 1, 0, 2'b00, 2'b10, 0);
        exp_a[4] = c_fetch;
        run_instr("ldsp_wait", 8'h08, 5, 9, 3, -1);

        // Asynchronous abort in m2 of LD (a16),SP
        i_Opcode = 8'h08; i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        repeat (9) tick();
        check("abort pre ctl", w_obs, exp_a[2]);
        #2 rst = 1'b1;
        #1 check("abort async", {o_Busy, o_M_Cycle, o_T_Step, w_obs}, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort held", {o_Busy, o_M_Cycle, o_T_Step, w_obs}, '0);
        clear_exp();
        exp_a[0] = c_fetch;
        run_instr("post_nop", 8'h00, 1, -1, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire
